lcd_io_driver: RTL

//  Consumer side of the CPU's memory-mapped LCD output word. Accepts command/data words

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_init_rom.sv | 22 ++
 rtl/lcd_io_driver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD output driver
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_LD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC,
        ST_IDLE
    } lcd_state_t;

    localparam int INIT_LEN   = 6;
    localparam int INIT_IDX_W = 3;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;

    localparam int IO_ON_BIT      = 31;
    localparam int IO_CLR_OVF_BIT = 30;
    localparam int IO_RS_BIT      = 9;
    localparam int IO_DATA_LSB    = 0;
    localparam int IO_DATA_W      = 8;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_OVF_BIT  = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// rtl/lcd_init_rom.sv - HD44780 power-up command sequence
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [INIT_IDX_W-1:0] i_idx,
    output logic [7:0]            o_cmd,
    output logic                  o_last
);

    always_comb begin
        o_cmd = CMD_ENTRY;
        case (i_idx)
            3'd0, 3'd1, 3'd2: o_cmd = CMD_FUNC_SET;
            3'd3:             o_cmd = CMD_DISP_ON;
            3'd4:             o_cmd = CMD_CLEAR;
            default:          o_cmd = CMD_ENTRY;
        endcase
    end

    assign o_last = (i_idx == INIT_IDX_W'(INIT_LEN - 1));

endmodule

// File: rtl/lcd_io_driver.sv
// rtl/lcd_io_driver.sv - replays CPU LCD words to an HD44780 bus with EN/RS timing
module lcd_io_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC   = 750000,
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int SLOW_EXEC_CYC = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_lcd_i,
    input  logic        io_lcd_wr_i,
    output logic [31:0] status_o,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);

    localparam int MAX_CYC = max_int(max_int(max_int(POWERUP_CYC, SLOW_EXEC_CYC),
                                             max_int(EXEC_CYC, PULSE_CYC)),
                                     max_int(SETUP_CYC, HOLD_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    lcd_state_t              r_state, w_next_state;
    logic [CNT_W-1:0]        r_cnt, w_last_cnt;
    logic [INIT_IDX_W-1:0]   r_idx;
    logic                    r_init;
    logic                    r_on, r_rs, r_en, r_ovf;
    logic [7:0]              r_data;
    logic                    r_slot_full, r_slot_on, r_slot_rs;
    logic [7:0]              r_slot_data;

    logic [7:0]  w_rom_cmd;
    logic        w_rom_last;
    logic        w_done, w_slow, w_busy;
    logic        w_start_slot, w_start_direct, w_capture, w_drop;
    logic [7:0]  w_wr_data;
    logic        w_unused_bits;

    lcd_init_rom u_rom (
        .i_idx  (r_idx),
        .o_cmd  (w_rom_cmd),
        .o_last (w_rom_last)
    );

    assign w_wr_data      = io_lcd_i[IO_DATA_LSB +: IO_DATA_W];
    assign w_unused_bits  = ^{io_lcd_i[29:10], io_lcd_i[8]};
    assign w_slow         = !r_rs && (r_data >= 8'h01) && (r_data <= 8'h03);
    assign w_done         = (r_cnt == w_last_cnt);
    assign w_start_slot   = (r_state == ST_IDLE) && r_slot_full;
    assign w_start_direct = (r_state == ST_IDLE) && !r_slot_full && io_lcd_wr_i;
    // The slot frees in the cycle it starts, so a write in that same cycle refills it
    assign w_capture      = io_lcd_wr_i && !w_start_direct && (!r_slot_full || w_start_slot);
    assign w_drop         = io_lcd_wr_i && !w_start_direct && r_slot_full && !w_start_slot;
    assign w_busy         = !((r_state == ST_IDLE) && !r_slot_full);

    always_comb begin
        status_o                = '0;
        status_o[STAT_BUSY_BIT] = w_busy;
        status_o[STAT_OVF_BIT]  = r_ovf;
    end

    always_comb begin
        w_last_cnt = '0;
        case (r_state)
            ST_PWRUP: w_last_cnt = CNT_W'(POWERUP_CYC - 1);
            ST_SETUP: w_last_cnt = CNT_W'(SETUP_CYC - 1);
            ST_PULSE: w_last_cnt = CNT_W'(PULSE_CYC - 1);
            ST_HOLD:  w_last_cnt = CNT_W'(HOLD_CYC - 1);
            ST_EXEC:  w_last_cnt = w_slow ? CNT_W'(SLOW_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
            default:  w_last_cnt = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_PWRUP:   if (w_done) w_next_state = ST_INIT_LD;
            ST_INIT_LD: w_next_state = ST_SETUP;
            ST_SETUP:   if (w_done) w_next_state = ST_PULSE;
            ST_PULSE:   if (w_done) w_next_state = ST_HOLD;
            ST_HOLD:    if (w_done) w_next_state = ST_EXEC;
            ST_EXEC:    if (w_done) w_next_state = (r_init && !w_rom_last) ? ST_INIT_LD : ST_IDLE;
            ST_IDLE:    if (w_start_slot || w_start_direct) w_next_state = ST_SETUP;
            default:    w_next_state = ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_PWRUP;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_init      <= 1'b0;
            r_on        <= 1'b0;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_data      <= '0;
            r_ovf       <= 1'b0;
            r_slot_full <= 1'b0;
            r_slot_on   <= 1'b0;
            r_slot_rs   <= 1'b0;
            r_slot_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // EN is registered so it tracks PULSE exactly without decode glitches
            r_en <= (w_next_state == ST_PULSE);

            if (r_state == ST_PWRUP && w_done) begin
                r_on   <= 1'b1;
                r_idx  <= '0;
                r_init <= 1'b1;
            end
            if (r_state == ST_INIT_LD) begin
                r_rs   <= 1'b0;
                r_data <= w_rom_cmd;
            end
            if (r_state == ST_EXEC && w_done && r_init) begin
                if (w_rom_last) r_init <= 1'b0;
                else            r_idx  <= r_idx + 1'b1;
            end

            if (w_start_slot) begin
                r_on   <= r_slot_on;
                r_rs   <= r_slot_rs;
                r_data <= r_slot_data;
            end else if (w_start_direct) begin
                r_on   <= io_lcd_i[IO_ON_BIT];
                r_rs   <= io_lcd_i[IO_RS_BIT];
                r_data <= w_wr_data;
            end

            if (w_capture) begin
                r_slot_full <= 1'b1;
                r_slot_on   <= io_lcd_i[IO_ON_BIT];
                r_slot_rs   <= io_lcd_i[IO_RS_BIT];
                r_slot_data <= w_wr_data;
            end else if (w_start_slot) begin
                r_slot_full <= 1'b0;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (io_lcd_wr_i && io_lcd_i[IO_CLR_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign lcd_on_o   = r_on;
    assign lcd_en_o   = r_en;
    assign lcd_rs_o   = r_rs;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = r_data;

endmodule
